d_cache_wt: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the external memory bus.
- It consumes the load/store requests gated by the pipeline control unit (ldst/wmem), using the physical address produced by the DTLB.
- It produces the memory stall signal st that freezes the pipeline while an access is outstanding.
- Lines are one 32-bit word. Reads and writes share one memory-transaction FSM.

---
 rtl/d_cache_wt.sv | 134 +++++++++++++
 tb/tb_d_cache_wt.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/d_cache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Read hits complete combinationally; every other access runs one memory transaction.
module d_cache_wt #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] p_a,
  input  logic [31:0] p_din,
  input  logic        p_strobe,
  input  logic        p_rw,
  input  logic        p_uncached,
  output logic [31:0] p_dout,
  output logic        p_ready,
  output logic        st,
  output logic [31:0] m_a,
  output logic [31:0] m_dout,
  input  logic [31:0] m_din,
  output logic        m_strobe,
  output logic        m_rw,
  input  logic        m_ready,
  output logic [31:0] rd_hits,
  output logic [31:0] rd_misses
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [0:0] {IDLE = 1'b0, MEM = 1'b1} state_t;

  state_t                state_r, state_s;
  logic [LINES-1:0]      valid_r;
  logic [TAG_BITS-1:0]   tag_r  [LINES];
  logic [31:0]           data_r [LINES];
  logic [31:0]           m_a_r, m_dout_r;
  logic                  m_rw_r, unc_r;

  logic [INDEX_BITS-1:0] p_idx_s, m_idx_s;
  logic [TAG_BITS-1:0]   p_tag_s, m_tag_s;
  logic                  p_hit_s, m_hit_s;
  logic                  rd_hit_s, start_s, done_s, fill_s, upd_s;

  assign p_idx_s = p_a[INDEX_BITS+1:2];
  assign p_tag_s = p_a[31:INDEX_BITS+2];
  // The transaction's own latched address drives the MEM-side lookup, so a
  // cancelled request (p_strobe dropped) still fills/updates the right line.
  assign m_idx_s = m_a_r[INDEX_BITS+1:2];
  assign m_tag_s = m_a_r[31:INDEX_BITS+2];

  assign p_hit_s  = valid_r[p_idx_s] & (tag_r[p_idx_s] == p_tag_s) & ~p_uncached;
  assign m_hit_s  = valid_r[m_idx_s] & (tag_r[m_idx_s] == m_tag_s) & ~unc_r;

  assign rd_hit_s = (state_r == IDLE) & p_strobe & ~p_rw & p_hit_s;
  assign start_s  = (state_r == IDLE) & p_strobe & ~rd_hit_s;
  assign done_s   = (state_r == MEM) & m_ready & ~rst;
  assign fill_s   = done_s & ~m_rw_r & ~unc_r;
  assign upd_s    = done_s & m_rw_r & m_hit_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start_s) state_s = MEM; else state_s = IDLE;
      MEM:     if (m_ready) state_s = IDLE; else state_s = MEM;
      default: state_s = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    p_ready  = 1'b0;
    p_dout   = data_r[p_idx_s];
    m_strobe = 1'b0;
    if (rst) begin
      p_ready  = 1'b0;
      m_strobe = 1'b0;
    end else begin
      case (state_r)
        IDLE: p_ready = rd_hit_s;
        MEM: begin
          m_strobe = 1'b1;
          p_ready  = m_ready;
          p_dout   = m_din;
        end
        default: p_ready = 1'b0;
      endcase
    end
  end

  assign st     = p_strobe & ~p_ready;
  assign m_a    = m_a_r;
  assign m_dout = m_dout_r;
  assign m_rw   = m_rw_r;

  // Memory request latch, valid bits and hit/miss counters
  always_ff @(posedge clk) begin
    if (rst) begin
      m_a_r     <= 32'h0000_0000;
      m_dout_r  <= 32'h0000_0000;
      m_rw_r    <= 1'b0;
      unc_r     <= 1'b0;
      valid_r   <= '0;
      rd_hits   <= 32'h0000_0000;
      rd_misses <= 32'h0000_0000;
    end else begin
      if (start_s) begin
        m_a_r    <= p_a & 32'hFFFF_FFFC;
        m_dout_r <= p_din;
        m_rw_r   <= p_rw;
        unc_r    <= p_uncached;
        if (~p_rw & ~p_uncached) rd_misses <= rd_misses + 32'd1;
      end
      if (rd_hit_s) rd_hits <= rd_hits + 32'd1;
      if (fill_s)   valid_r[m_idx_s] <= 1'b1;
    end
  end

  // Tag/data arrays: filled on read completion, patched on store hit
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_r[m_idx_s]  <= m_tag_s;
      data_r[m_idx_s] <= m_din;
    end else if (upd_s) begin
      data_r[m_idx_s] <= m_dout_r;
    end
  end

endmodule

// File: tb/tb_d_cache_wt.sv
// Directed self-checking bench for d_cache_wt: hits, misses, write-through,
// no-write-allocate, conflict replacement, uncached bypass and reset mid-miss.
module tb_d_cache_wt;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] p_a = 32'h0, p_din = 32'h0, m_din = 32'h0;
  logic        p_strobe = 1'b0, p_rw = 1'b0, p_uncached = 1'b0, m_ready = 1'b0;
  logic [31:0] p_dout, m_a, m_dout, rd_hits, rd_misses;
  logic        p_ready, st, m_strobe, m_rw;

  int vec = 0, errs = 0;

  // Values recorded by mem_txn for the test tasks to compare
  int          r_st;
  logic        r_ok, r_rdy, r_mrw;
  logic [31:0] r_dout, r_ma, r_mdo;

  d_cache_wt #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .p_a(p_a), .p_din(p_din), .p_strobe(p_strobe),
    .p_rw(p_rw), .p_uncached(p_uncached), .p_dout(p_dout), .p_ready(p_ready),
    .st(st), .m_a(m_a), .m_dout(m_dout), .m_din(m_din), .m_strobe(m_strobe),
    .m_rw(m_rw), .m_ready(m_ready), .rd_hits(rd_hits), .rd_misses(rd_misses)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic req(input logic [31:0] a, input logic rw, input logic [31:0] din, input logic unc);
    p_a = a; p_rw = rw; p_din = din; p_uncached = unc; p_strobe = 1'b1;
  endtask

  task automatic drop();
    p_strobe = 1'b0; p_rw = 1'b0; p_uncached = 1'b0;
  endtask

  // Memory responder: answers n cycles after m_strobe rises; request already driven.
  task automatic mem_txn(input int n, input logic [31:0] din);
    int sc;
    sc = 0; r_st = 0; r_ok = 1'b0; r_rdy = 1'b0; r_dout = 32'h0;
    r_ma = 32'hFFFF_FFFF; r_mrw = 1'bx; r_mdo = 32'h0;
    for (int c = 0; c < 30 && !r_ok; c++) begin
      if (sc == n) begin m_ready = 1'b1; m_din = din; end
      @(negedge clk);
      if (st) r_st++;
      if (m_strobe) begin
        if (sc == 0) begin r_ma = m_a; r_mrw = m_rw; r_mdo = m_dout; end
        sc++;
      end
      if (m_ready) begin r_rdy = p_ready; r_dout = p_dout; r_ok = 1'b1; end
      tick();
      m_ready = 1'b0;
    end
    drop();
  endtask

  task automatic test_reset();
    req(32'h0000_0100, 1'b0, 32'h0, 1'b0);
    tick(); tick();
    @(negedge clk);
    vec++; if (p_ready !== 1'b0) begin errs++; $display("FAIL reset_p_ready got %b want 0", p_ready); end
    vec++; if (m_strobe !== 1'b0) begin errs++; $display("FAIL reset_m_strobe got %b want 0", m_strobe); end
    drop(); tick(); rst = 1'b0;
    @(negedge clk);
    vec++; if ({rd_hits, rd_misses} !== 64'h0) begin errs++; $display("FAIL reset_counters got %h/%h want 0/0", rd_hits, rd_misses); end
    vec++; if ({m_a, m_dout, m_rw} !== 65'h0) begin errs++; $display("FAIL reset_mregs got %h/%h/%b want 0", m_a, m_dout, m_rw); end
    tick();
  endtask

  task automatic test_cold_miss();
    req(32'h0000_0100, 1'b0, 32'h0, 1'b0);
    mem_txn(2, 32'hDEAD_BEEF);
    vec++; if (r_ok !== 1'b1) begin errs++; $display("FAIL cold_miss_timeout got %b want 1", r_ok); end
    vec++; if (r_st != 3) begin errs++; $display("FAIL cold_miss_st_cycles got %0d want 3", r_st); end
    vec++; if (r_ma !== 32'h0000_0100 || r_mrw !== 1'b0) begin errs++; $display("FAIL cold_miss_mreq got %h/%b want 00000100/0", r_ma, r_mrw); end
    vec++; if (r_rdy !== 1'b1 || r_dout !== 32'hDEAD_BEEF) begin errs++; $display("FAIL cold_miss_data got %b/%h want 1/deadbeef", r_rdy, r_dout); end
    @(negedge clk);
    vec++; if (rd_misses !== 32'd1 || rd_hits !== 32'd0) begin errs++; $display("FAIL cold_miss_counters got %0d/%0d want 0/1", rd_hits, rd_misses); end
  endtask

  task automatic test_read_hit(input logic [31:0] a, input logic [31:0] exp, input logic [31:0] exp_hits);
    tick();
    req(a, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    vec++; if (p_ready !== 1'b1 || p_dout !== exp) begin errs++; $display("FAIL read_hit_data got %b/%h want 1/%h", p_ready, p_dout, exp); end
    vec++; if (st !== 1'b0 || m_strobe !== 1'b0) begin errs++; $display("FAIL read_hit_nomem got st=%b m_strobe=%b want 0/0", st, m_strobe); end
    tick(); drop();
    @(negedge clk);
    vec++; if (rd_hits !== exp_hits) begin errs++; $display("FAIL read_hit_count got %0d want %0d", rd_hits, exp_hits); end
    vec++; if (m_strobe !== 1'b0) begin errs++; $display("FAIL read_hit_idle got m_strobe=%b want 0", m_strobe); end
  endtask

  task automatic test_store_hit();
    tick();
    req(32'h0000_0100, 1'b1, 32'h1234_5678, 1'b0);
    mem_txn(1, 32'h0);
    vec++; if (r_ok !== 1'b1 || r_rdy !== 1'b1) begin errs++; $display("FAIL store_hit_done got %b/%b want 1/1", r_ok, r_rdy); end
    vec++; if (r_mrw !== 1'b1 || r_mdo !== 32'h1234_5678 || r_ma !== 32'h0000_0100) begin errs++; $display("FAIL store_hit_mreq got %b/%h/%h want 1/12345678/00000100", r_mrw, r_mdo, r_ma); end
    vec++; if (r_st != 2) begin errs++; $display("FAIL store_hit_st_cycles got %0d want 2", r_st); end
    test_read_hit(32'h0000_0100, 32'h1234_5678, 32'd2);
  endtask

  task automatic test_store_miss_conflict();
    tick();
    req(32'h0000_0200, 1'b1, 32'hCAFE_F00D, 1'b0);
    mem_txn(1, 32'h0);
    vec++; if (r_ok !== 1'b1 || r_mdo !== 32'hCAFE_F00D || r_ma !== 32'h0000_0200) begin errs++; $display("FAIL store_miss_mreq got %b/%h/%h want 1/cafef00d/00000200", r_ok, r_mdo, r_ma); end
    tick();
    req(32'h0000_0200, 1'b0, 32'h0, 1'b0);
    mem_txn(3, 32'h0BAD_F00D);
    vec++; if (r_st != 4 || r_dout !== 32'h0BAD_F00D) begin errs++; $display("FAIL no_alloc_load_miss got st=%0d/%h want 4/0badf00d", r_st, r_dout); end
    tick();
    req(32'h0000_0100, 1'b0, 32'h0, 1'b0);
    mem_txn(1, 32'h1234_5678);
    vec++; if (r_st != 2 || r_ma !== 32'h0000_0100 || r_dout !== 32'h1234_5678) begin errs++; $display("FAIL conflict_miss got st=%0d/%h/%h want 2/00000100/12345678", r_st, r_ma, r_dout); end
    @(negedge clk);
    vec++; if (rd_misses !== 32'd3 || rd_hits !== 32'd2) begin errs++; $display("FAIL conflict_counters got %0d/%0d want 2/3", rd_hits, rd_misses); end
  endtask

  task automatic test_uncached();
    logic [31:0] din [2];
    din[0] = 32'h5555_5555; din[1] = 32'h6666_6666;
    for (int i = 0; i < 2; i++) begin
      tick();
      req(32'h0000_0100, 1'b0, 32'h0, 1'b1);
      mem_txn(1, din[i]);
      vec++; if (r_st != 2 || r_ma !== 32'h0000_0100 || r_dout !== din[i]) begin errs++; $display("FAIL uncached_load%0d got st=%0d/%h/%h want 2/00000100/%h", i, r_st, r_ma, r_dout, din[i]); end
    end
    @(negedge clk);
    vec++; if (rd_misses !== 32'd3 || rd_hits !== 32'd2) begin errs++; $display("FAIL uncached_counters got %0d/%0d want 2/3", rd_hits, rd_misses); end
    test_read_hit(32'h0000_0100, 32'h1234_5678, 32'd3);
  endtask

  task automatic test_reset_mid_miss();
    tick();
    req(32'h0000_0300, 1'b0, 32'h0, 1'b0);
    tick();
    @(negedge clk);
    vec++; if (m_strobe !== 1'b1) begin errs++; $display("FAIL mid_miss_in_mem got m_strobe=%b want 1", m_strobe); end
    tick(); rst = 1'b1; drop();
    tick(); rst = 1'b0; m_ready = 1'b1; m_din = 32'hBBBB_BBBB;
    @(negedge clk);
    vec++; if (m_strobe !== 1'b0 || p_ready !== 1'b0) begin errs++; $display("FAIL after_rst_strobe got %b/%b want 0/0", m_strobe, p_ready); end
    tick(); m_ready = 1'b0;
    @(negedge clk);
    vec++; if (m_strobe !== 1'b0 || rd_misses !== 32'd0 || rd_hits !== 32'd0) begin errs++; $display("FAIL late_ready_ignored got %b/%0d/%0d want 0/0/0", m_strobe, rd_hits, rd_misses); end
    tick();
    req(32'h0000_0100, 1'b0, 32'h0, 1'b0);
    mem_txn(1, 32'h7777_7777);
    vec++; if (r_st != 2 || r_dout !== 32'h7777_7777) begin errs++; $display("FAIL post_rst_miss got st=%0d/%h want 2/77777777", r_st, r_dout); end
    @(negedge clk);
    vec++; if (rd_misses !== 32'd1) begin errs++; $display("FAIL post_rst_count got %0d want 1", rd_misses); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_read_hit(32'h0000_0100, 32'hDEAD_BEEF, 32'd1);
    test_store_hit();
    test_store_miss_conflict();
    test_uncached();
    test_reset_mid_miss();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
